// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding (common to receiver and transmitter),
// legal frame lengths and the parity rule.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_DONE   = 3'd6
  } uart_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int LEN_MIN        = 5;
  localparam int LEN_MAX        = 8;

  // ptype=1 gives the XOR of the used data bits, ptype=0 its complement.
  function automatic logic uart_parity(input logic [7:0] data,
                                       input logic [3:0] length,
                                       input logic       ptype);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(length)) acc = acc ^ data[i];
    end
    return ptype ? acc : ~acc;
  endfunction

  function automatic logic uart_len_legal(input logic [3:0] length);
    return (length >= 4'(LEN_MIN)) && (length <= 4'(LEN_MAX));
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Request/status bundle between a frame producer and the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  // tx_start is a level request sampled only while the transmitter is idle;
  // tx_busy low means the next tx_start edge is accepted (or rejected via tx_error).
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  length;
  logic        parity_en;
  logic        parity_type;
  logic        stop2;
  logic        tx;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_error;
  uart_state_e state_dbg;

  modport master (
    output tx_start, tx_data, length, parity_en, parity_type, stop2,
    input  tx, tx_busy, tx_done, tx_error, state_dbg
  );

  modport slave (
    input  tx_start, tx_data, length, parity_en, parity_type, stop2,
    output tx, tx_busy, tx_done, tx_error, state_dbg
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional parity,
// 1 or 2 stop bits, each bit held for OVERSAMPLE clocks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int   OVERSAMPLE = OVERSAMPLE_DEF,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic      rx_clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_PARITY = ST_PARITY;
  localparam logic [2:0] S_STOP1  = ST_STOP1;
  localparam logic [2:0] S_STOP2  = ST_STOP2;
  localparam logic [2:0] S_DONE   = ST_DONE;

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [TW-1:0] tick;
  logic [2:0]    bit_idx;
  logic [7:0]    data_q;
  logic [3:0]    len_q;
  logic          pen_q;
  logic          s2_q;
  logic          par_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          line_lvl;
  logic          tick_last;
  logic          last_data;
  logic          accept;
  logic          reject;

  assign tick_last = (tick == TW'(OVERSAMPLE - 1));
  assign last_data = ({1'b0, bit_idx} == (len_q - 4'd1));
  assign accept    = (state == S_IDLE) && bus.tx_start && uart_len_legal(bus.length);
  assign reject    = (state == S_IDLE) && bus.tx_start && !uart_len_legal(bus.length);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept)    state_nx = S_START;
      S_START:  if (tick_last) state_nx = S_DATA;
      S_DATA:   if (tick_last && last_data) state_nx = pen_q ? S_PARITY : S_STOP1;
      S_PARITY: if (tick_last) state_nx = S_STOP1;
      S_STOP1:  if (tick_last) state_nx = s2_q ? S_STOP2 : S_DONE;
      S_STOP2:  if (tick_last) state_nx = S_DONE;
      S_DONE:                  state_nx = S_IDLE;
      default:                 state_nx = S_IDLE;
    endcase
  end

  // Line level for the current state; registered into tx one clock later,
  // which is why the start bit shows up on the edge after acceptance.
  always_comb begin
    line_lvl = IDLE_LEVEL;
    case (state)
      S_START:  line_lvl = ~IDLE_LEVEL;
      S_DATA:   line_lvl = data_q[bit_idx];
      S_PARITY: line_lvl = par_q;
      default:  line_lvl = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tick    <= '0;
      bit_idx <= '0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      tx_q   <= line_lvl;
      busy_q <= (state != S_IDLE);
      done_q <= (state == S_DONE);
      err_q  <= reject;

      if (state == S_IDLE || state == S_DONE || tick_last) tick <= '0;
      else                                                  tick <= tick + TW'(1);

      if (state != S_DATA)  bit_idx <= '0;
      else if (tick_last)   bit_idx <= bit_idx + 3'd1;
    end
  end

  // Frame configuration is frozen at acceptance; parity is precomputed so the
  // PARITY state only has to drive a stored bit.
  always_ff @(posedge rx_clk) begin
    if (accept) begin
      data_q <= bus.tx_data;
      len_q  <= bus.length;
      pen_q  <= bus.parity_en;
      s2_q   <= bus.stop2;
      par_q  <= uart_parity(bus.tx_data, bus.length, bus.parity_type);
    end
  end

  assign bus.tx        = tx_q;
  assign bus.tx_busy   = busy_q;
  assign bus.tx_done   = done_q;
  assign bus.tx_error  = err_q;
  assign bus.state_dbg = uart_state_e'(state);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed cases plus randomized back-to-back
// loopback, checked against a frame-level model and a line decoder.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int OS = 16;

  typedef struct {
    logic [11:0] bits;
    int          n;
    int          len;
    logic [7:0]  data;
  } frame_t;

  logic rx_clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;

  uart_tx_if bus ();

  uart_tx #(.OVERSAMPLE(OS), .IDLE_LEVEL(1'b1)) dut (
    .rx_clk (rx_clk),
    .rst    (rst),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  initial cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic frame_t make_frame(input logic [7:0] d, input int len,
                                        input bit pen, input bit ptype, input bit s2);
    frame_t f;
    int     ones;
    f.bits = '0;
    f.len  = len;
    f.data = '0;
    ones   = 0;
    for (int i = 0; i < len; i++) begin
      f.bits[1 + i] = d[i];
      f.data[i]     = d[i];
      ones          = ones + int'(d[i]);
    end
    f.n = 1 + len;
    if (pen) begin
      f.bits[f.n] = ptype ? ((ones % 2) == 1) : ((ones % 2) == 0);
      f.n = f.n + 1;
    end
    f.bits[f.n] = 1'b1;
    f.n = f.n + 1;
    if (s2) begin
      f.bits[f.n] = 1'b1;
      f.n = f.n + 1;
    end
    return f;
  endfunction

  frame_t exp_q[$];
  int     exp_frames;

  // ---------------- line decoder / scoreboard ----------------
  frame_t     cur;
  bit         in_frame;
  bit         done_due;
  bit         post_done;
  bit         b2b_mode;
  bit         b2b_armed;
  int         pos;
  int         frames_done;
  int         done_cnt;
  int         last_done;
  logic [7:0] rx_word;
  logic       prev_tx;

  initial begin
    in_frame = 0; done_due = 0; post_done = 0; b2b_mode = 0; b2b_armed = 0;
    pos = 0; frames_done = 0; done_cnt = 0; last_done = 0; rx_word = '0;
  end

  always @(negedge rx_clk) begin
    if (rst) begin
      in_frame  = 0;
      done_due  = 0;
      post_done = 0;
    end else begin
      if (bus.tx_done === 1'b1) done_cnt++;
      if (done_due) begin
        check("done_time", bus.tx_done, 1);
        check("busy_in_done", bus.tx_busy, 1);
        done_due  = 0;
        post_done = 1;
        last_done = cyc;
        b2b_armed = b2b_mode;
        frames_done++;
      end else if (post_done) begin
        check("busy_after_done", bus.tx_busy, 0);
        post_done = 0;
      end
      if (!in_frame && prev_tx === 1'b1 && bus.tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          cur      = exp_q.pop_front();
          in_frame = 1;
          pos      = 0;
          rx_word  = '0;
          if (b2b_armed) check("b2b_gap", cyc - last_done, 2);
          b2b_armed = 0;
        end
      end
      if (in_frame) begin
        check("tx_bit", bus.tx, cur.bits[pos / OS]);
        if ((pos % OS) == OS / 2 && (pos / OS) >= 1 && (pos / OS) <= cur.len)
          rx_word[(pos / OS) - 1] = bus.tx;
        pos++;
        if (pos == cur.n * OS) begin
          in_frame = 0;
          done_due = 1;
          check("rx_out", rx_word, cur.data);
        end
      end
    end
    prev_tx = bus.tx;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cfg(input logic [7:0] d, input logic [3:0] len,
                           input bit pen, input bit ptype, input bit s2);
    bus.tx_data     = d;
    bus.length      = len;
    bus.parity_en   = pen;
    bus.parity_type = ptype;
    bus.stop2       = s2;
    if (len >= 4'd5 && len <= 4'd8) begin
      exp_q.push_back(make_frame(d, int'(len), pen, ptype, s2));
      exp_frames++;
    end
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frames_done < target && t < 3000) begin
      @(negedge rx_clk);
      t++;
    end
    check("frame_timeout", frames_done, target);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [3:0] len,
                            input bit pen, input bit ptype, input bit s2);
    int     acc;
    frame_t f;
    @(posedge rx_clk); #1;
    drive_cfg(d, len, pen, ptype, s2);
    bus.tx_start = 1'b1;
    @(posedge rx_clk); #1;
    acc = cyc;
    bus.tx_start = 1'b0;
    if (len < 4'd5 || len > 4'd8) begin
      @(negedge rx_clk);
      check("err_pulse", bus.tx_error, 1);
      check("err_tx_idle", bus.tx, 1);
      check("err_busy", bus.tx_busy, 0);
      @(negedge rx_clk);
      check("err_one_cycle", bus.tx_error, 0);
      check("err_busy2", bus.tx_busy, 0);
      check("err_tx_idle2", bus.tx, 1);
    end else begin
      f = make_frame(d, int'(len), pen, ptype, s2);
      wait_frames(exp_frames);
      check("done_latency", last_done - acc, 1 + f.n * OS);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int t;
    n_cmp = 0; n_err = 0; exp_frames = 0;
    rst = 1'b1;
    bus.tx_start = 1'b0; bus.tx_data = '0; bus.length = 4'd8;
    bus.parity_en = 1'b0; bus.parity_type = 1'b0; bus.stop2 = 1'b0;
    repeat (3) @(posedge rx_clk);
    @(negedge rx_clk);
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_done", bus.tx_done, 0);
    check("rst_err", bus.tx_error, 0);
    check("rst_state", bus.state_dbg, ST_IDLE);
    @(posedge rx_clk); #1 rst = 1'b0;

    // Case 1 and 2: directed frames
    send_frame(8'hA5, 4'd8, 1, 1, 0);
    send_frame(8'h13, 4'd5, 1, 0, 1);

    // Case 3: illegal length, then a normal 7-bit frame
    send_frame(8'h55, 4'd4, 0, 0, 0);
    send_frame(8'h6B, 4'd7, 0, 1, 0);

    // Case 4: request and config changes while busy
    @(posedge rx_clk); #1;
    drive_cfg(8'h3C, 4'd8, 1, 0, 0);
    bus.tx_start = 1'b1;
    @(posedge rx_clk); #1 bus.tx_start = 1'b0;
    repeat (OS * 3) @(posedge rx_clk);
    #1;
    bus.tx_data = 8'hFF; bus.length = 4'd5; bus.parity_en = 1'b0; bus.stop2 = 1'b1;
    bus.tx_start = 1'b1;
    @(posedge rx_clk); #1 bus.tx_start = 1'b0;
    repeat (20) @(posedge rx_clk);
    #1 bus.length = 4'd6; bus.parity_en = 1'b1;
    wait_frames(exp_frames);
    repeat (300) @(negedge rx_clk);
    check("busy_drop_tx", bus.tx, 1);
    check("busy_drop_busy", bus.tx_busy, 0);
    check("busy_drop_q", exp_q.size(), 0);

    // Case 5: reset during data bit 3
    @(posedge rx_clk); #1;
    drive_cfg(8'h5A, 4'd8, 0, 0, 0);
    bus.tx_start = 1'b1;
    @(posedge rx_clk); #1 bus.tx_start = 1'b0;
    repeat (OS * 4 + 5) @(posedge rx_clk);
    #1 rst = 1'b1;
    @(posedge rx_clk); #1 rst = 1'b0;
    exp_frames--;
    @(negedge rx_clk);
    check("midrst_tx", bus.tx, 1);
    check("midrst_busy", bus.tx_busy, 0);
    check("midrst_done", bus.tx_done, 0);
    check("midrst_state", bus.state_dbg, ST_IDLE);
    d0 = done_cnt;
    repeat (250) @(negedge rx_clk);
    check("midrst_no_done", done_cnt, d0);
    send_frame(8'hC3, 4'd8, 1, 1, 1);

    // Case 6: back-to-back loopback over all configurations, random payloads
    b2b_mode = 1;
    @(posedge rx_clk); #1;
    drive_cfg(8'($urandom_range(0, 255)), 4'd5, 0, 0, 0);
    bus.tx_start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      t = 0;
      do begin
        @(negedge rx_clk);
        t++;
      end while (bus.tx_done !== 1'b1 && t < 400);
      check("b2b_done_seen", bus.tx_done, 1);
      if (i < 31)
        drive_cfg(8'($urandom_range(0, 255)), 4'(5 + ((i + 1) % 4)),
                  bit'(((i + 1) >> 2) & 1), bit'(((i + 1) >> 3) & 1),
                  bit'(((i + 1) >> 4) & 1));
      else
        bus.tx_start = 1'b0;
    end
    wait_frames(exp_frames);
    b2b_mode = 0;
    @(posedge rx_clk); #1 b2b_armed = 0;

    // Random single requests, including illegal lengths
    for (int i = 0; i < 6; i++)
      send_frame(8'($urandom_range(0, 255)), 4'($urandom_range(3, 9)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)));

    repeat (50) @(negedge rx_clk);
    check("done_count", done_cnt, frames_done);
    check("queue_empty", exp_q.size(), 0);
    check("frames_total", frames_done, exp_frames);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
